rpn_calculator_core: RTL and testbench

//  Parametrised RPN successor to the infix calculator FSM. Holds entry register X plus an operand stack
//  of STACK_DEPTH entries. Accepts keypad codes over a valid/ready handshake and issues binary ops (Y op X)
//  to the external ALU. Pushes every new X value to the display driver. Sits between keypad decoder, ALU and display driver.

---
 rtl/rpn_calculator_core_pkg.sv | 44 ++++
 rtl/rpn_calculator_core_if.sv | 60 ++++++
 rtl/rpn_calculator_core_operand_stack.sv | 77 +++++++
 rtl/rpn_calculator_core.sv | 227 ++++++++++++++++++++++
 tb/tb_rpn_calculator_core.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rpn_calculator_core_pkg.sv
// rtl/rpn_calculator_core_pkg.sv - key codes, ALU op and FSM state types for the RPN calculator core
package rpn_calculator_core_pkg;

  // Command keys carry bit 4 set; digits carry bit 4 clear with the nibble value below.
  localparam logic [4:0] KEY_ADD   = 5'b10000;
  localparam logic [4:0] KEY_SUB   = 5'b10001;
  localparam logic [4:0] KEY_MUL   = 5'b10010;
  localparam logic [4:0] KEY_DIV   = 5'b10011;
  localparam logic [4:0] KEY_ENTER = 5'b10100;
  localparam logic [4:0] KEY_NEG   = 5'b10101;
  localparam logic [4:0] KEY_AC    = 5'b10110;
  localparam logic [4:0] KEY_DROP  = 5'b10111;
  localparam logic [4:0] KEY_SWAP  = 5'b11000;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_MUL = 2'b10,
    ALU_DIV = 2'b11
  } alu_op_t;

  typedef enum logic [2:0] {
    S_WAIT,
    S_EXEC,
    S_ALU_REQ,
    S_ALU_RSP,
    S_DISPLAY,
    S_ERROR
  } rpn_state_t;

  // One stack action per cycle; the core never needs two at once.
  typedef enum logic [2:0] {
    STK_NONE,
    STK_PUSH,
    STK_POP,
    STK_WR_TOP,
    STK_CLEAR
  } stack_op_t;

  function automatic logic key_is_digit(input logic [4:0] key);
    return !key[4];
  endfunction

endpackage

// File: rtl/rpn_calculator_core_if.sv
// rtl/rpn_calculator_core_if.sv - keypad, ALU and display bus of the RPN calculator core
interface rpn_calculator_core_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int STACK_DEPTH = 4
);
  import rpn_calculator_core_pkg::*;

  localparam int CNT_W = $clog2(STACK_DEPTH + 1);

  // Keypad
  logic [4:0]            i_button_data;
  logic                  i_button_valid;
  logic                  o_button_ready;
  logic                  i_2s_comp_mode;

  // ALU request / response
  logic [DATA_WIDTH-1:0] o_alu_input_a;
  logic [DATA_WIDTH-1:0] o_alu_input_b;
  alu_op_t               o_alu_input_op;
  logic                  o_alu_input_signed;
  logic                  o_alu_input_valid;
  logic                  i_alu_input_ready;
  logic [DATA_WIDTH-1:0] i_alu_result;
  logic                  i_alu_error;
  logic                  i_alu_result_valid;
  logic                  o_alu_result_ready;

  // Status and display
  logic [CNT_W-1:0]      o_stack_count;
  logic                  o_error;
  logic [DATA_WIDTH-1:0] o_display_data;
  logic                  o_display_2s_comp;
  logic                  o_display_valid;
  logic                  i_display_ready;

  // Calculator core side
  modport slave (
    input  i_button_data, i_button_valid, i_2s_comp_mode,
    input  i_alu_input_ready, i_alu_result, i_alu_error, i_alu_result_valid,
    input  i_display_ready,
    output o_button_ready,
    output o_alu_input_a, o_alu_input_b, o_alu_input_op, o_alu_input_signed, o_alu_input_valid,
    output o_alu_result_ready,
    output o_stack_count, o_error,
    output o_display_data, o_display_2s_comp, o_display_valid
  );

  // Keypad decoder / ALU / display driver side
  modport master (
    output i_button_data, i_button_valid, i_2s_comp_mode,
    output i_alu_input_ready, i_alu_result, i_alu_error, i_alu_result_valid,
    output i_display_ready,
    input  o_button_ready,
    input  o_alu_input_a, o_alu_input_b, o_alu_input_op, o_alu_input_signed, o_alu_input_valid,
    input  o_alu_result_ready,
    input  o_stack_count, o_error,
    input  o_display_data, o_display_2s_comp, o_display_valid
  );

endinterface

// File: rtl/rpn_calculator_core_operand_stack.sv
// rtl/rpn_calculator_core_operand_stack.sv - shift-register operand stack with saturating count
module rpn_calculator_core_operand_stack
  import rpn_calculator_core_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int STACK_DEPTH = 4,
  parameter int CNT_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  stack_op_t             op_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] top_o,
  output logic [CNT_W-1:0]      count_o
);

  // Entry 0 is the top of stack (Y); higher indices are deeper.
  logic [DATA_WIDTH-1:0] mem_q [STACK_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [STACK_DEPTH];
  logic [CNT_W-1:0]      count_q, count_d;

  localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(STACK_DEPTH);

  // Next-state for push/pop/top-write/clear; a full push drops the bottom entry.
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    case (op_i)
      STK_PUSH: begin
        for (int i = STACK_DEPTH - 1; i > 0; i--) begin
          mem_d[i] = mem_q[i-1];
        end
        mem_d[0] = din_i;
        if (count_q != COUNT_FULL) begin
          count_d = count_q + 1'b1;
        end
      end
      STK_POP: begin
        if (count_q != '0) begin
          for (int i = 0; i < STACK_DEPTH - 1; i++) begin
            mem_d[i] = mem_q[i+1];
          end
          mem_d[STACK_DEPTH-1] = '0;
          count_d = count_q - 1'b1;
        end
      end
      STK_WR_TOP: begin
        mem_d[0] = din_i;
      end
      STK_CLEAR: begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
          mem_d[i] = '0;
        end
        count_d = '0;
      end
      default: begin
      end
    endcase
  end

  // Stack storage and occupancy register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
    end
  end

  assign top_o   = mem_q[0];
  assign count_o = count_q;

endmodule

// File: rtl/rpn_calculator_core.sv
// rtl/rpn_calculator_core.sv - RPN calculator control core: keypad entry, operand stack, ALU and display sequencing
module rpn_calculator_core
  import rpn_calculator_core_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  rpn_calculator_core_if.slave bus
);

  localparam int CNT_W = $clog2(STACK_DEPTH + 1);

  rpn_state_t            state_q, state_d;
  logic [4:0]            key_q, key_d;
  logic [DATA_WIDTH-1:0] x_q, x_d;
  logic                  entry_active_q, entry_active_d;
  logic                  entry_neg_q, entry_neg_d;
  logic                  lift_q, lift_d;
  logic                  error_q, error_d;

  stack_op_t             stk_op;
  logic [DATA_WIDTH-1:0] stk_din;
  logic [DATA_WIDTH-1:0] stk_top;
  logic [CNT_W-1:0]      stk_count;
  logic                  stk_empty;

  logic                  button_ready;
  logic                  key_accept;

  logic [DATA_WIDTH-1:0] digit_ext;
  logic [DATA_WIDTH-1:0] x_shift;
  logic [DATA_WIDTH-1:0] acc_addend;
  logic [DATA_WIDTH-1:0] acc_sum;
  logic [DATA_WIDTH-1:0] neg_x;

  rpn_calculator_core_operand_stack #(
    .DATA_WIDTH  (DATA_WIDTH),
    .STACK_DEPTH (STACK_DEPTH),
    .CNT_W       (CNT_W)
  ) u_stack (
    .clk     (clk),
    .rst     (rst),
    .op_i    (stk_op),
    .din_i   (stk_din),
    .top_o   (stk_top),
    .count_o (stk_count)
  );

  assign stk_empty    = (stk_count == '0);
  assign button_ready = (state_q == S_WAIT) || (state_q == S_ERROR);
  assign key_accept   = bus.i_button_valid && button_ready;

  // Digit accumulation: subtracting d is adding ~d with carry-in, so one adder covers both signs.
  assign digit_ext  = {{(DATA_WIDTH-4){1'b0}}, key_q[3:0]};
  assign x_shift    = {x_q[DATA_WIDTH-5:0], 4'h0};
  assign acc_addend = entry_neg_q ? ~digit_ext : digit_ext;
  assign acc_sum    = x_shift + acc_addend + {{(DATA_WIDTH-1){1'b0}}, entry_neg_q};
  assign neg_x      = ~x_q + {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  // Next-state, register updates and stack commands for the key/ALU/display sequence.
  always_comb begin
    state_d        = state_q;
    key_d          = key_q;
    x_d            = x_q;
    entry_active_d = entry_active_q;
    entry_neg_d    = entry_neg_q;
    lift_d         = lift_q;
    error_d        = error_q;
    stk_op         = STK_NONE;
    stk_din        = x_q;

    case (state_q)
      S_WAIT: begin
        if (key_accept) begin
          key_d   = bus.i_button_data;
          state_d = S_EXEC;
        end
      end

      S_ERROR: begin
        // Keys are swallowed here; only AC gets through to EXEC to recover.
        if (key_accept && (bus.i_button_data == KEY_AC)) begin
          key_d   = bus.i_button_data;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        state_d = S_DISPLAY;
        if (key_is_digit(key_q)) begin
          if (!entry_active_q) begin
            if (lift_q) begin
              stk_op = STK_PUSH;
            end
            x_d            = digit_ext;
            entry_active_d = 1'b1;
            entry_neg_d    = 1'b0;
          end else begin
            x_d = acc_sum;
          end
        end else begin
          case (key_q)
            KEY_ADD, KEY_SUB, KEY_MUL, KEY_DIV: begin
              if (stk_empty) begin
                error_d = 1'b1;
                state_d = S_ERROR;
              end else begin
                state_d = S_ALU_REQ;
              end
            end
            KEY_ENTER: begin
              stk_op         = STK_PUSH;
              entry_active_d = 1'b0;
              lift_d         = 1'b0;
            end
            KEY_NEG: begin
              x_d = neg_x;
              if (entry_active_q) begin
                entry_neg_d = ~entry_neg_q;
              end
            end
            KEY_AC: begin
              stk_op         = STK_CLEAR;
              x_d            = '0;
              entry_active_d = 1'b0;
              entry_neg_d    = 1'b0;
              lift_d         = 1'b1;
              error_d        = 1'b0;
            end
            KEY_DROP: begin
              x_d    = stk_empty ? '0 : stk_top;
              stk_op = STK_POP;
            end
            KEY_SWAP: begin
              if (stk_empty) begin
                state_d = S_WAIT;
              end else begin
                x_d     = stk_top;
                stk_din = x_q;
                stk_op  = STK_WR_TOP;
              end
            end
            default: begin
              state_d = S_WAIT;
            end
          endcase
        end
      end

      S_ALU_REQ: begin
        if (bus.i_alu_input_ready) begin
          state_d = S_ALU_RSP;
        end
      end

      S_ALU_RSP: begin
        if (bus.i_alu_result_valid) begin
          if (bus.i_alu_error) begin
            error_d = 1'b1;
            state_d = S_ERROR;
          end else begin
            stk_op         = STK_POP;
            x_d            = bus.i_alu_result;
            entry_active_d = 1'b0;
            lift_d         = 1'b1;
            state_d        = S_DISPLAY;
          end
        end
      end

      S_DISPLAY: begin
        if (bus.i_display_ready) begin
          state_d = S_WAIT;
        end
      end

      default: begin
        state_d = S_WAIT;
      end
    endcase
  end

  // FSM state register; reset lands in DISPLAY so the cleared X is shown once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_DISPLAY;
    end else begin
      state_q <= state_d;
    end
  end

  // Entry register, latched key and entry/lift/error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q          <= '0;
      x_q            <= '0;
      entry_active_q <= 1'b0;
      entry_neg_q    <= 1'b0;
      lift_q         <= 1'b1;
      error_q        <= 1'b0;
    end else begin
      key_q          <= key_d;
      x_q            <= x_d;
      entry_active_q <= entry_active_d;
      entry_neg_q    <= entry_neg_d;
      lift_q         <= lift_d;
      error_q        <= error_d;
    end
  end

  assign bus.o_button_ready     = button_ready;
  assign bus.o_alu_input_a      = stk_top;
  assign bus.o_alu_input_b      = x_q;
  assign bus.o_alu_input_op     = alu_op_t'(key_q[1:0]);
  assign bus.o_alu_input_signed = bus.i_2s_comp_mode;
  assign bus.o_alu_input_valid  = (state_q == S_ALU_REQ);
  assign bus.o_alu_result_ready = (state_q == S_ALU_RSP);
  assign bus.o_stack_count      = stk_count;
  assign bus.o_error            = error_q;
  assign bus.o_display_data     = x_q;
  assign bus.o_display_2s_comp  = bus.i_2s_comp_mode;
  // The reset state is DISPLAY, so the valid is held off while rst is still asserted.
  assign bus.o_display_valid    = (state_q == S_DISPLAY) && !rst;

endmodule

// File: tb/tb_rpn_calculator_core.sv
// tb/tb_rpn_calculator_core.sv - randomized bench for rpn_calculator_core against a stack-queue model
module tb_rpn_calculator_core;
  import rpn_calculator_core_pkg::*;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int K_NONE = 0;
  localparam int K_DISP = 1;
  localparam int K_ALU  = 2;
  localparam int K_ERR  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rpn_calculator_core_if #(.DATA_WIDTH(DW), .STACK_DEPTH(DEPTH)) bus ();

  rpn_calculator_core #(.DATA_WIDTH(DW), .STACK_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int alu_cnt = 0;
  logic force_err = 1'b0;

  always @(posedge clk) if (bus.o_alu_input_valid) alu_cnt++;

  // Reference model: X plus a queue whose front is the stack top.
  logic [DW-1:0] m_x;
  logic [DW-1:0] m_stk[$];
  logic m_ea, m_en, m_lift, m_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_x = '0; m_stk.delete(); m_ea = 1'b0; m_en = 1'b0; m_lift = 1'b1; m_err = 1'b0;
  endtask

  task automatic m_push(input logic [DW-1:0] v);
    m_stk.push_front(v);
    if (m_stk.size() > DEPTH) void'(m_stk.pop_back());
  endtask

  task automatic model_key(input logic [4:0] k, output int kind);
    logic [DW-1:0] d16;
    logic [DW-1:0] t;
    d16 = {12'd0, k[3:0]};
    kind = K_NONE;
    if (m_err) begin
      if (k == KEY_AC) begin model_reset(); kind = K_DISP; end
    end else if (!k[4]) begin
      if (!m_ea) begin
        if (m_lift) m_push(m_x);
        m_x = d16; m_ea = 1'b1; m_en = 1'b0;
      end else if (m_en) m_x = m_x * 16'd16 - d16;
      else m_x = m_x * 16'd16 + d16;
      kind = K_DISP;
    end else begin
      case (k)
        KEY_ADD, KEY_SUB, KEY_MUL, KEY_DIV: begin
          if (m_stk.size() == 0) begin m_err = 1'b1; kind = K_ERR; end
          else kind = K_ALU;
        end
        KEY_ENTER: begin m_push(m_x); m_ea = 1'b0; m_lift = 1'b0; kind = K_DISP; end
        KEY_NEG: begin m_x = 16'd0 - m_x; if (m_ea) m_en = !m_en; kind = K_DISP; end
        KEY_AC: begin model_reset(); kind = K_DISP; end
        KEY_DROP: begin
          if (m_stk.size() == 0) m_x = '0; else m_x = m_stk.pop_front();
          kind = K_DISP;
        end
        KEY_SWAP: begin
          if (m_stk.size() != 0) begin t = m_stk[0]; m_stk[0] = m_x; m_x = t; kind = K_DISP; end
        end
        default: kind = K_NONE;
      endcase
    end
  endtask

  task automatic send_key(input logic [4:0] k);
    int n;
    @(negedge clk);
    bus.i_button_data = k; bus.i_button_valid = 1'b1;
    n = 0;
    while (!bus.o_button_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.o_button_ready) check_eq("key_tmo", 32'd0, 32'd1);
    @(negedge clk);
    bus.i_button_valid = 1'b0;
  endtask

  task automatic expect_display(input int hold, input int lat);
    int n;
    n = 0;
    while (!bus.o_display_valid && n < 20) begin @(negedge clk); n++; end
    if (!bus.o_display_valid) begin check_eq("disp_tmo", 32'd0, 32'd1); return; end
    if (lat >= 0) check_eq("disp_lat", 32'(n), 32'(lat));
    check_eq("disp_data", 32'(bus.o_display_data), 32'(m_x));
    check_eq("disp_2s", 32'(bus.o_display_2s_comp), 32'(bus.i_2s_comp_mode));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("hold_dv", 32'(bus.o_display_valid), 32'd1);
      check_eq("hold_data", 32'(bus.o_display_data), 32'(m_x));
      check_eq("hold_rdy", 32'(bus.o_button_ready), 32'd0);
    end
    bus.i_display_ready = 1'b1;
    @(negedge clk);
    bus.i_display_ready = 1'b0;
  endtask

  task automatic expect_quiet(input logic chk_alu, input int alu_before);
    repeat (3) begin
      @(negedge clk);
      check_eq("quiet_dv", 32'(bus.o_display_valid), 32'd0);
    end
    if (chk_alu) check_eq("no_alu", 32'(alu_cnt), 32'(alu_before));
  endtask

  task automatic alu_exchange(input logic [1:0] op, input logic [DW-1:0] y, input logic [DW-1:0] x,
                              output logic [DW-1:0] res, output logic err);
    int n;
    res = '0; err = 1'b0;
    n = 0;
    while (!bus.o_alu_input_valid && n < 20) begin @(negedge clk); n++; end
    if (!bus.o_alu_input_valid) begin check_eq("alu_tmo", 32'd0, 32'd1); err = 1'b1; return; end
    check_eq("alu_a", 32'(bus.o_alu_input_a), 32'(y));
    check_eq("alu_b", 32'(bus.o_alu_input_b), 32'(x));
    check_eq("alu_op", 32'(bus.o_alu_input_op), 32'(op));
    check_eq("alu_sgn", 32'(bus.o_alu_input_signed), 32'(bus.i_2s_comp_mode));
    repeat ($urandom_range(0, 2)) @(negedge clk);
    bus.i_alu_input_ready = 1'b1;
    @(negedge clk);
    bus.i_alu_input_ready = 1'b0;
    n = 0;
    while (!bus.o_alu_result_ready && n < 20) begin @(negedge clk); n++; end
    if (!bus.o_alu_result_ready) begin check_eq("rsp_tmo", 32'd0, 32'd1); err = 1'b1; return; end
    case (op)
      2'd0: res = y + x;
      2'd1: res = y - x;
      2'd2: res = y * x;
      default: begin
        if (x == '0) err = 1'b1;
        else if (bus.i_2s_comp_mode) res = $signed(y) / $signed(x);
        else res = y / x;
      end
    endcase
    if (force_err || $urandom_range(0, 15) == 0) err = 1'b1;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    bus.i_alu_result = res; bus.i_alu_error = err; bus.i_alu_result_valid = 1'b1;
    @(negedge clk);
    bus.i_alu_result_valid = 1'b0; bus.i_alu_error = 1'b0;
  endtask

  task automatic step(input logic [4:0] k, input int hold);
    int kind;
    int alu_before;
    logic [DW-1:0] res, y;
    logic rerr;
    bus.i_2s_comp_mode = 1'($urandom_range(0, 1));
    model_key(k, kind);
    alu_before = alu_cnt;
    send_key(k);
    case (kind)
      K_DISP: expect_display(hold, 1);
      K_ALU: begin
        y = m_stk[0];
        alu_exchange(k[1:0], y, m_x, res, rerr);
        if (rerr) begin m_err = 1'b1; expect_quiet(1'b0, alu_before); end
        else begin
          void'(m_stk.pop_front());
          m_x = res; m_ea = 1'b0; m_lift = 1'b1;
          expect_display(hold, -1);
        end
      end
      default: expect_quiet(1'b1, alu_before);
    endcase
    check_eq("count", 32'(bus.o_stack_count), 32'(m_stk.size()));
    check_eq("error", 32'(bus.o_error), 32'(m_err));
    check_eq("ready", 32'(bus.o_button_ready), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.i_button_valid = 1'b0; bus.i_alu_input_ready = 1'b0;
    bus.i_alu_result_valid = 1'b0; bus.i_display_ready = 1'b0;
    #1;
    check_eq("rst_dv", 32'(bus.o_display_valid), 32'd0);
    check_eq("rst_av", 32'(bus.o_alu_input_valid), 32'd0);
    check_eq("rst_rr", 32'(bus.o_alu_result_ready), 32'd0);
    check_eq("rst_br", 32'(bus.o_button_ready), 32'd0);
    @(negedge clk);
    check_eq("rst_cnt", 32'(bus.o_stack_count), 32'd0);
    check_eq("rst_err", 32'(bus.o_error), 32'd0);
    rst = 1'b0;
    model_reset();
    expect_display(0, -1);
    check_eq("rst_rdy", 32'(bus.o_button_ready), 32'd1);
  endtask

  function automatic logic [4:0] rand_key();
    int r;
    logic [4:0] cmds [8];
    cmds = '{KEY_ADD, KEY_SUB, KEY_MUL, KEY_DIV, KEY_ENTER, KEY_NEG, KEY_DROP, KEY_SWAP};
    r = $urandom_range(0, 99);
    if (r < 45) return {1'b0, 4'($urandom_range(0, 15))};
    if (r < 51) return KEY_AC;
    if (r < 55) return {1'b1, 4'($urandom_range(9, 15))};
    return cmds[$urandom_range(0, 7)];
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    bus.i_button_data = '0; bus.i_button_valid = 1'b0; bus.i_2s_comp_mode = 1'b0;
    bus.i_alu_input_ready = 1'b0; bus.i_alu_result = '0; bus.i_alu_error = 1'b0;
    bus.i_alu_result_valid = 1'b0; bus.i_display_ready = 1'b0;
    model_reset();

    // Reset shows 0 once, then accepts keys
    do_reset();

    // 1 2 ENTER 3 ADD: ALU sees a=0x12 b=3 op=ADD
    step(5'h01, 0); step(5'h02, 0); step(KEY_ENTER, 0); step(5'h03, 0);
    check_eq("t2_x", 32'(bus.o_display_data), 32'h3);
    force_err = 1'b0;
    step(KEY_ADD, 0);

    // Stack saturation and drain to empty
    step(KEY_AC, 0); step(5'h05, 0);
    repeat (6) step(KEY_ENTER, 0);
    check_eq("t3_full", 32'(bus.o_stack_count), 32'(DEPTH));
    repeat (5) step(KEY_DROP, 0);
    check_eq("t3_zero", 32'(bus.o_display_data), 32'd0);

    // ALU error path, ignored digit, AC recovery
    step(KEY_AC, 0); step(5'h07, 0); step(KEY_ENTER, 0); step(5'h00, 0);
    force_err = 1'b1;
    step(KEY_DIV, 0);
    force_err = 1'b0;
    step(5'h09, 0); step(KEY_AC, 0);

    // Op at empty stack: error without an ALU request
    step(KEY_ADD, 0); step(KEY_AC, 0);

    // Negative entry and swap
    step(5'h04, 0); step(KEY_NEG, 0); step(5'h02, 0); step(KEY_ENTER, 0);
    step(5'h01, 0); step(KEY_SWAP, 0); step(5'h1f, 0);

    // Display back-pressure for 10 cycles
    step(5'h03, 10);

    // Reset while an ALU request is outstanding
    step(5'h06, 0); step(KEY_ENTER, 0);
    send_key(KEY_MUL);
    begin
      int n;
      n = 0;
      while (!bus.o_alu_input_valid && n < 20) begin @(negedge clk); n++; end
      check_eq("mid_av", 32'(bus.o_alu_input_valid), 32'd1);
    end
    do_reset();

    // Random key sequence
    for (int i = 0; i < 300; i++) begin
      step(rand_key(), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
